station_cmd_ctrl: RTL and testbench
===================================

// Module: station_cmd_ctrl
// PURPOSE
//  Sequences the barcode reader for the follower. Accepts GO/STOP commands from the UART
//  command path and latches a 6-bit destination station. Consumes each decoded ID/ID_vld
//  from the barcode block and clears it via clr_ID_vld. Drives go to the motion
//  controller, stops at the matching station, and sounds the obstacle buzzer.
// PARAMETERS
//  BUZZ_DIV  12500     buzzer half-period in clk cycles (>=2)
//  TIMEOUT   50000000  clk cycles of motion with no barcode before abort (>=2)
//  TO_W      26        width of the timeout counter; must hold TIMEOUT
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst          in   1  asynchronous, active-high reset
//  cmd_rdy      in   1  command byte available (level, held until cleared)
//  cmd          in   8  [7:6] opcode: 01=GO, 00=STOP, 1x=ignored; [5:0] destination ID
//  clr_cmd_rdy  out  1  1-cycle pulse: command consumed
//  ID_vld       in   1  barcode ID available (level, held until cleared)
//  ID           in   8  decoded station ID; valid only if ID[7:6]==2'b00
//  clr_ID_vld   out  1  1-cycle pulse: barcode ID consumed
//  OK2Move      in   1  1 = path clear (no obstacle)
//  go           out  1  motion enable = in_transit & OK2Move
//  in_transit   out  1  1 while in TRANSIT
//  dest_ID      out  6  latched destination
//  timeout      out  1  1-cycle pulse on watchdog abort
//  buzz, buzz_n out  1  piezo drive, complementary
// BEHAVIOUR
//  Reset: state=IDLE, dest_ID=0, in_transit=0, go=0, clr_*=0, timeout=0, buzz=0,
//   buzz_n=1, all counters 0. Reset mid-transit aborts immediately; pending flags
//   are not cleared.
//  clr_cmd_rdy/clr_ID_vld are combinational (Mealy) on the cycle the flag is consumed.
//   At most one flag is consumed per cycle. cmd has priority; an unconsumed ID_vld is
//   served next cycle.
//  IDLE: cmd_rdy & opcode GO -> dest_ID<=cmd[5:0], clr_cmd_rdy, -> TRANSIT.
//   cmd_rdy & other opcode -> clr_cmd_rdy, stay IDLE.
//   ID_vld (no cmd_rdy) -> clr_ID_vld, ID discarded.
//  TRANSIT:
//   - cmd_rdy & STOP -> clr_cmd_rdy, -> IDLE.
//   - cmd_rdy & GO -> clr_cmd_rdy, dest_ID<=cmd[5:0], stay.
//   - cmd_rdy & 1x -> clr_cmd_rdy, stay.
//   - else ID_vld -> clr_ID_vld. If ID[7:6]==00 and ID[5:0]==dest_ID -> IDLE; else stay
//     (invalid IDs such as 0xFF and 0x81 never stop).
//  in_transit is registered; go is combinational from in_transit & OK2Move.
//  Watchdog: counter resets on entry to TRANSIT and on any consumed cmd or ID.
//   Increments only while go=1; holds while go=0.
//   On reaching TIMEOUT-1 with go=1, the next edge goes to IDLE and timeout pulses for
//   one cycle.
//   A same-cycle cmd or ID takes priority: counter resets and there is no timeout.
//  Buzzer: active when in_transit & ~OK2Move. The divider counts to BUZZ_DIV-1, then
//   wraps to 0 and toggles buzz. When inactive, the divider clears, buzz=0, buzz_n=1.
//   buzz_n = ~buzz at all times.
//  dest_ID holds its value in IDLE; it is only overwritten by a GO.
// TESTING (barcode_mimic + barcode in loop, period=22'h000111; TIMEOUT reduced in bench)
//  1 GO dest 0x04, send IDs 0x01 then 0x04 -> stays TRANSIT after 0x01; IDLE, go=0
//    after 0x04; one clr_ID_vld pulse per ID.
//  2 GO dest 0x3F, send 0xFF then 0x81 -> both cleared, still TRANSIT (upper bits !=00).
//  3 GO 0x20 in transit, OK2Move=0 for 3*BUZZ_DIV -> go=0, buzz toggles every BUZZ_DIV
//    cycles, buzz_n complementary; OK2Move=1 -> buzz=0, go=1.
//  4 cmd_rdy(STOP) and ID_vld(match) same cycle -> clr_cmd_rdy this cycle,
//    clr_ID_vld next cycle, ends IDLE.
//  5 GO 0x10, no barcodes, OK2Move=1 for TIMEOUT cycles -> timeout pulse, IDLE;
//    OK2Move=0 periods extend the deadline exactly.
//  6 rst asserted mid-TRANSIT while buzzing -> all outputs at reset values immediately.

Source files
------------

// File: rtl/station_cmd_if.sv
// Command/barcode/motion bundle between the station sequencer and its neighbours.
// The slave side is the sequencer; the master side is whoever drives the command
// path, barcode decoder and obstacle sensor.
interface station_cmd_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       clr_cmd_rdy;
  logic       ID_vld;
  logic [7:0] ID;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       go;
  logic       in_transit;
  logic [5:0] dest_ID;
  logic       timeout;
  logic       buzz;
  logic       buzz_n;

  modport slave (
    input  cmd_rdy, cmd, ID_vld, ID, OK2Move,
    output clr_cmd_rdy, clr_ID_vld, go, in_transit, dest_ID, timeout, buzz, buzz_n
  );

  modport master (
    output cmd_rdy, cmd, ID_vld, ID, OK2Move,
    input  clr_cmd_rdy, clr_ID_vld, go, in_transit, dest_ID, timeout, buzz, buzz_n
  );
endinterface

// File: rtl/station_cmd_ctrl.sv
// Station command sequencer: takes GO/STOP commands, tracks the destination station,
// stops when the matching barcode is read, aborts on a motion watchdog and drives the
// obstacle buzzer while blocked in transit.
module station_cmd_ctrl #(
  parameter int unsigned BUZZ_DIV = 12500,
  parameter int unsigned TIMEOUT  = 50000000,
  parameter int unsigned TO_W     = 26
) (
  input  logic        clk,
  input  logic        rst,
  station_cmd_if.slave bus
);

  localparam int unsigned BW = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [BW-1:0]   DivMax = BW'(BUZZ_DIV - 1);
  localparam logic [TO_W-1:0] ToMax  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] OpStop = 2'b00;
  localparam logic [1:0] OpGo   = 2'b01;

  typedef enum logic [0:0] {StIdle, StTransit} state_e;

  state_e          state_q, state_d;
  logic [5:0]      dest_q, dest_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic [BW-1:0]   div_q, div_d;
  logic            buzz_q, buzz_d;

  logic       in_transit;
  logic       go;
  logic       clr_cmd;
  logic       clr_id;
  logic       buzz_active;
  logic [1:0] op;
  logic       id_match;

  assign in_transit  = (state_q == StTransit);
  assign go          = in_transit & bus.OK2Move;
  assign buzz_active = in_transit & ~bus.OK2Move;
  assign op          = bus.cmd[7:6];
  // Only IDs with a clear upper field can name a station.
  assign id_match    = (bus.ID[7:6] == 2'b00) && (bus.ID[5:0] == dest_q);

  // Flag consumption: cmd wins; a pending ID waits one cycle behind it.
  always_comb begin
    clr_cmd = bus.cmd_rdy;
    clr_id  = bus.ID_vld & ~bus.cmd_rdy;
  end

  // Next-state, destination latch and watchdog.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (bus.cmd_rdy && (op == OpGo)) begin
          dest_d  = bus.cmd[5:0];
          state_d = StTransit;
        end
      end
      StTransit: begin
        if (bus.cmd_rdy) begin
          to_cnt_d = '0;
          case (op)
            OpStop:  state_d = StIdle;
            OpGo:    dest_d  = bus.cmd[5:0];
            default: ;
          endcase
        end else if (bus.ID_vld) begin
          to_cnt_d = '0;
          if (id_match) state_d = StIdle;
        end else if (go) begin
          if (to_cnt_q == ToMax) begin
            to_cnt_d  = '0;
            timeout_d = 1'b1;
            state_d   = StIdle;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Buzzer divider: toggles buzz every BUZZ_DIV cycles while blocked in transit.
  always_comb begin
    div_d  = div_q;
    buzz_d = buzz_q;
    if (!buzz_active) begin
      div_d  = '0;
      buzz_d = 1'b0;
    end else if (div_q == DivMax) begin
      div_d  = '0;
      buzz_d = ~buzz_q;
    end else begin
      div_d = div_q + BW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dest_q    <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      div_q     <= '0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      div_q     <= div_d;
      buzz_q    <= buzz_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_cmd;
  assign bus.clr_ID_vld  = clr_id;
  assign bus.go          = go;
  assign bus.in_transit  = in_transit;
  assign bus.dest_ID     = dest_q;
  assign bus.timeout     = timeout_q;
  assign bus.buzz        = buzz_q;
  assign bus.buzz_n      = ~buzz_q;

endmodule

// File: tb/tb_station_cmd_ctrl.sv
// Bench for station_cmd_ctrl: a vector table for single-cycle command/ID handling plus
// hand-written sequences for buzzer, same-cycle arbitration, watchdog and reset.
module tb_station_cmd_ctrl;
  localparam int unsigned BuzzDiv = 4;
  localparam int unsigned Timeout = 20;
  localparam int unsigned ToW     = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  station_cmd_if bus ();

  station_cmd_ctrl #(
    .BUZZ_DIV(BuzzDiv),
    .TIMEOUT (Timeout),
    .TO_W    (ToW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       cmd_rdy;
    logic [7:0] cmd;
    logic       id_vld;
    logic [7:0] id;
    logic       ok;
    logic       e_clr_cmd;
    logic       e_clr_id;
    logic       e_go;
    logic       e_transit;
    logic [5:0] e_dest;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic cr, input logic [7:0] c, input logic iv,
                              input logic [7:0] i, input logic ok, input logic ecc,
                              input logic eci, input logic eg, input logic et,
                              input logic [5:0] ed);
    vec_t v;
    v.cmd_rdy = cr; v.cmd = c; v.id_vld = iv; v.id = i; v.ok = ok;
    v.e_clr_cmd = ecc; v.e_clr_id = eci; v.e_go = eg; v.e_transit = et; v.e_dest = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector for one cycle: Mealy outputs checked mid-cycle, state after the edge.
  task automatic apply(input vec_t t, input string tag);
    vec_t e;
    bus.cmd_rdy = t.cmd_rdy; bus.cmd = t.cmd;
    bus.ID_vld  = t.id_vld;  bus.ID  = t.id;
    bus.OK2Move = t.ok;
    sb.push_back(t);
    #3;
    e = sb.pop_front();
    chk({tag, ".clr_cmd_rdy"}, 32'(bus.clr_cmd_rdy), 32'(e.e_clr_cmd));
    chk({tag, ".clr_ID_vld"},  32'(bus.clr_ID_vld),  32'(e.e_clr_id));
    chk({tag, ".go"},          32'(bus.go),          32'(e.e_go));
    tick();
    bus.cmd_rdy = 1'b0;
    bus.ID_vld  = 1'b0;
    chk({tag, ".in_transit"}, 32'(bus.in_transit), 32'(e.e_transit));
    chk({tag, ".dest_ID"},    32'(bus.dest_ID),    32'(e.e_dest));
    chk({tag, ".timeout"},    32'(bus.timeout),    32'd0);
  endtask

  // Counts cycles from now until the timeout pulse; OK2Move low in [hold_lo, hold_hi).
  task automatic wait_timeout(input int exp_k, input int hold_lo, input int hold_hi,
                              input string name);
    int found = -1;
    int k = 0;
    while (found < 0 && k < 200) begin
      if (bus.timeout) begin
        found = k;
      end else begin
        bus.OK2Move = !(k >= hold_lo && k < hold_hi);
        tick();
        k++;
      end
    end
    chk({name, ".cycles"}, 32'(found), 32'(exp_k));
    if (found >= 0) begin
      chk({name, ".idle"}, 32'(bus.in_transit), 32'd0);
      tick();
      chk({name, ".one_pulse"}, 32'(bus.timeout), 32'd0);
    end
    bus.OK2Move = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00;
    bus.ID_vld  = 1'b0; bus.ID  = 8'h00;
    bus.OK2Move = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_transit", 32'(bus.in_transit), 32'd0);
    chk("reset.go",         32'(bus.go),         32'd0);
    chk("reset.dest_ID",    32'(bus.dest_ID),    32'd0);
    chk("reset.timeout",    32'(bus.timeout),    32'd0);
    chk("reset.buzz",       32'(bus.buzz),       32'd0);
    chk("reset.buzz_n",     32'(bus.buzz_n),     32'd1);
    chk("reset.clr_cmd",    32'(bus.clr_cmd_rdy), 32'd0);
    chk("reset.clr_id",     32'(bus.clr_ID_vld),  32'd0);
    rst = 1'b0;
    tick();

    //                  cr  cmd    iv  id     ok  ecc eci eg  et  dest
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 6'h00)); // idle, quiet
    vecs.push_back(mk(0, 8'h00, 1, 8'h05, 1, 0, 1, 0, 0, 6'h00)); // ID discarded in idle
    vecs.push_back(mk(1, 8'h07, 0, 8'h00, 1, 1, 0, 0, 0, 6'h00)); // STOP in idle
    vecs.push_back(mk(1, 8'hC4, 0, 8'h00, 1, 1, 0, 0, 0, 6'h00)); // ignored opcode
    vecs.push_back(mk(1, 8'h44, 0, 8'h00, 1, 1, 0, 0, 1, 6'h04)); // GO 0x04
    vecs.push_back(mk(0, 8'h00, 1, 8'h01, 1, 0, 1, 1, 1, 6'h04)); // wrong station
    vecs.push_back(mk(0, 8'h00, 1, 8'h04, 1, 0, 1, 1, 0, 6'h04)); // arrive
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 6'h04)); // dest held in idle
    vecs.push_back(mk(1, 8'h7F, 0, 8'h00, 1, 1, 0, 0, 1, 6'h3F)); // GO 0x3F
    vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 1, 0, 1, 1, 1, 6'h3F)); // invalid ID
    vecs.push_back(mk(0, 8'h00, 1, 8'h81, 1, 0, 1, 1, 1, 6'h3F)); // invalid ID
    vecs.push_back(mk(1, 8'hA0, 0, 8'h00, 1, 1, 0, 1, 1, 6'h3F)); // ignored in transit
    vecs.push_back(mk(1, 8'h60, 0, 8'h00, 1, 1, 0, 1, 1, 6'h20)); // re-target 0x20
    vecs.push_back(mk(0, 8'h00, 1, 8'h3F, 1, 0, 1, 1, 1, 6'h20)); // old dest no longer hits
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 6'h20)); // blocked: go low
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 6'h20)); // STOP
    vecs.push_back(mk(1, 8'h45, 1, 8'h05, 1, 1, 0, 0, 1, 6'h05)); // cmd beats ID
    vecs.push_back(mk(0, 8'h00, 1, 8'h05, 1, 0, 1, 1, 0, 6'h05)); // deferred ID arrives
    vecs.push_back(mk(0, 8'h00, 1, 8'h45, 1, 0, 1, 0, 0, 6'h05)); // invalid ID in idle
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Buzzer: blocked for 3*BuzzDiv cycles, then released.
    apply(mk(1, 8'h60, 0, 8'h00, 1, 1, 0, 0, 1, 6'h20), "buzz.go");
    bus.OK2Move = 1'b0;
    for (int c = 0; c < 3 * int'(BuzzDiv); c++) begin
      #3;
      chk($sformatf("buzz.c%0d.buzz", c), 32'(bus.buzz), 32'((c / BuzzDiv) % 2));
      chk($sformatf("buzz.c%0d.buzz_n", c), 32'(bus.buzz_n), 32'(1 - (c / BuzzDiv) % 2));
      chk($sformatf("buzz.c%0d.go", c), 32'(bus.go), 32'd0);
      tick();
    end
    bus.OK2Move = 1'b1;
    #3;
    chk("buzz.release.go", 32'(bus.go), 32'd1);
    tick();
    chk("buzz.release.buzz",   32'(bus.buzz),   32'd0);
    chk("buzz.release.buzz_n", 32'(bus.buzz_n), 32'd1);
    apply(mk(1, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 6'h20), "buzz.stop");

    // STOP and matching ID held together: cmd consumed first, ID next cycle.
    apply(mk(1, 8'h49, 0, 8'h00, 1, 1, 0, 0, 1, 6'h09), "both.go");
    bus.cmd_rdy = 1'b1; bus.cmd = 8'h00;
    bus.ID_vld  = 1'b1; bus.ID  = 8'h09;
    #3;
    chk("both.c0.clr_cmd", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("both.c0.clr_id",  32'(bus.clr_ID_vld),  32'd0);
    tick();
    bus.cmd_rdy = 1'b0;
    chk("both.c1.in_transit", 32'(bus.in_transit), 32'd0);
    #3;
    chk("both.c1.clr_cmd", 32'(bus.clr_cmd_rdy), 32'd0);
    chk("both.c1.clr_id",  32'(bus.clr_ID_vld),  32'd1);
    tick();
    bus.ID_vld = 1'b0;
    chk("both.end.in_transit", 32'(bus.in_transit), 32'd0);

    // Watchdog: five blocked cycles push the deadline out by exactly five.
    apply(mk(1, 8'h50, 0, 8'h00, 1, 1, 0, 0, 1, 6'h10), "wd.go");
    wait_timeout(Timeout + 5, 3, 8, "wd.hold");
    chk("wd.dest_kept", 32'(bus.dest_ID), 32'h10);

    // A command on the deadline cycle wins and restarts the count.
    apply(mk(1, 8'h50, 0, 8'h00, 1, 1, 0, 0, 1, 6'h10), "wd2.go");
    repeat (Timeout - 1) tick();
    apply(mk(1, 8'h51, 0, 8'h00, 1, 1, 0, 1, 1, 6'h11), "wd2.cmd_at_deadline");
    wait_timeout(Timeout, 0, 0, "wd2.restart");

    // Reset while buzzing in transit.
    apply(mk(1, 8'h6A, 0, 8'h00, 1, 1, 0, 0, 1, 6'h2A), "rst.go");
    bus.OK2Move = 1'b0;
    repeat (6) tick();
    chk("rst.pre.buzz", 32'(bus.buzz), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.in_transit", 32'(bus.in_transit), 32'd0);
    chk("rst.go",         32'(bus.go),         32'd0);
    chk("rst.buzz",       32'(bus.buzz),       32'd0);
    chk("rst.buzz_n",     32'(bus.buzz_n),     32'd1);
    chk("rst.dest_ID",    32'(bus.dest_ID),    32'd0);
    chk("rst.timeout",    32'(bus.timeout),    32'd0);
    tick();
    rst = 1'b0;
    bus.OK2Move = 1'b1;
    tick();
    chk("rst.after.in_transit", 32'(bus.in_transit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
